conv_depth_accum: RTL
=====================

// Module: conv_depth_accum
// PURPOSE
//  Downstream of the 3D conv window address generator: consumes one 5x5 window of pixels
//  (already fetched at the generator's 25 offsets) plus matching kernel weights per beat.
//  Computes the 25-tap dot product and accumulates it per output position across all input
//  depth slices in an internal partial-sum buffer; emits each finished output pixel on last depth.
//  Window order is position-major, depth-minor-outer (all 2D anchors of depth 0, then depth 1, ...).
// PARAMETERS
//  DATA_W          16   signed pixel/weight width
//  KERNAL_TAPS     25   taps per window (5x5)
//  ANCHOR_POS      961  anchors per depth slice (31*31); must be >= 4
//  DATA_DEPTH      1    input depth slices accumulated per output pixel
//  ACC_W           40   accumulator/output width (signed)
//  POS_W           16   width of position index
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 async active-low reset
//  clear      in   1                 sync flush: drop pipeline, zero counters
//  in_valid   in   1                 window beat valid
//  in_ready   out  1                 beat accepted when in_valid && in_ready
//  in_window  in   KERNAL_TAPS*DATA_W  pixels, tap j at [(j+1)*DATA_W-1 : j*DATA_W]
//  in_weight  in   KERNAL_TAPS*DATA_W  weights, same packing
//  in_bias    in   ACC_W             bias added once, sampled with the first-depth beat of each position
//  out_valid  out  1                 finished pixel valid
//  out_ready  in   1                 consumer ready
//  out_data   out  ACC_W             finished pixel
//  out_pos    out  POS_W             anchor index 0..ANCHOR_POS-1 of out_data
//  frame_done out  1                 1-cycle pulse with the handshake of the last pixel of a frame
// BEHAVIOUR
//  - Reset: rst_n is async active-low, clock clk. All outputs 0; in_ready=1; counters 0; stage valids 0.
//    Psum buffer is not reset (depth-0 write overwrites).
//  - Pipeline, 3 stages, each with valid bit: S1 registers 25 signed products (2*DATA_W);
//    S2 registers adder-tree sum (2*DATA_W+5, sign-extended); S3 reads psum[pos], writes result.
//  - Accept at cycle T -> out_valid earliest T+3 (last depth only).
//  - Counters advance on accept: pos 0..ANCHOR_POS-1 wraps to 0 and increments depth;
//    depth DATA_DEPTH-1 wraps to 0. pos/depth/last tags travel with each stage.
//  - S3: depth==0 -> acc = sum + bias; else acc = psum[pos] + sum. If depth==DATA_DEPTH-1 (incl. DEPTH=1):
//    present acc on out_data/out_pos, out_valid=1, no buffer write; else write psum[pos]=acc.
//  - All adds sign-extended to ACC_W, wrap on overflow (no saturation).
//  - Stall: stall = out_valid && !out_ready. Whole pipeline freezes; in_ready = !stall.
//    out_data/out_pos held stable while stalled. Buffer write-then-read hazard impossible
//    since same pos recurs ANCHOR_POS>=4 beats later.
//  - frame_done pulses in the cycle out_valid&&out_ready for pos==ANCHOR_POS-1.
//  - clear (priority over all else): stage valids, out_valid, counters -> 0 next cycle; in-flight beats lost.
//  - Bubbles (in_valid=0) propagate as invalid stages; counters hold.
// CONFIGURATION
//  CONV_ACCUM_RELU_EN defined: out_data = (acc<0) ? 0 : acc on final-depth output only; partial sums unclamped.
//  Not defined: out_data = acc (signed, may be negative).
// STRUCTURE
//  Package conv_pkg: DATA_W/ACC_W defaults, clog2 function, tap-slice macro-free helper
//  function get_tap(bus,j). Sub-module conv_mac_tree25: S1+S2 (products + pipelined sum),
//  with valid and enable (=!stall) ports. Psum buffer: inferred single-port-read/single-write RAM, ANCHOR_POS x ACC_W.
// TESTING
//  1) DEPTH=1, ANCHOR_POS=4, all pixels=1, weights=2, bias=3 -> 4 outputs of 53, pos 0..3, frame_done on pos 3.
//  2) DEPTH=3, ANCHOR_POS=4, pixels=depth+1, weights=1, bias=0 -> outputs 25+50+75=150 only after depth 2; none earlier.
//  3) Pixels=-1, weights=1, bias=0: without CONV_ACCUM_RELU_EN out=-25; with it out=0.
//  4) out_ready=0 for 5 cycles while out_valid -> in_ready=0, out_data/out_pos stable, no beat lost; totals match model.
//  5) Assert clear mid-depth 1 then restart stream -> first outputs equal fresh-frame values (depth-0 overwrites stale psum).
//  6) Random in_valid gaps + async rst_n mid-frame -> out_valid=0, in_ready=1 immediately; scoreboard vs reference model.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and helpers for the depth-accumulating 5x5 convolution datapath.
package conv_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned TAPS_DEF   = 25;

  // Ceiling log2 with a floor of 1 bit so degenerate sizes still get a usable index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic signed [DATA_W_DEF-1:0] get_tap(
    input logic [TAPS_DEF*DATA_W_DEF-1:0] bus,
    input int unsigned                    j
  );
    return bus[j*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/conv_mac_tree25.sv
// Two-stage multiply-accumulate: S1 registers per-tap signed products, S2 registers their sum.
// A side-band tag rides along with each beat; i_enable freezes both stages.
module conv_mac_tree25
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned SUM_W  = 2 * DATA_W_DEF + 5,
  parameter int unsigned TAG_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [TAPS*DATA_W-1:0]   i_window,
  input  logic [TAPS*DATA_W-1:0]   i_weight,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  output logic signed [SUM_W-1:0]  o_sum,
  output logic [TAG_W-1:0]         o_tag
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic                     r_s1_valid;
  logic                     r_s2_valid;
  logic [TAG_W-1:0]         r_s1_tag;
  logic [TAG_W-1:0]         r_s2_tag;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  r_s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (i_clear) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (i_enable) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (i_enable) begin
      for (int j = 0; j < int'(TAPS); j++) begin
        r_prod[j] <= PROD_W'($signed(i_window[j*DATA_W +: DATA_W]))
                   * PROD_W'($signed(i_weight[j*DATA_W +: DATA_W]));
      end
      r_s1_tag <= i_tag;
      r_s2_sum <= w_sum;
      r_s2_tag <= r_s1_tag;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < int'(TAPS); j++) begin
      w_sum = w_sum + SUM_W'(r_prod[j]);
    end
  end

  assign o_valid = r_s2_valid;
  assign o_sum   = r_s2_sum;
  assign o_tag   = r_s2_tag;

endmodule

// File: rtl/conv_depth_accum.sv
// 25-tap dot product accumulated per anchor across depth slices; emits on the last depth.
// Define CONV_ACCUM_RELU_EN to clamp negative final outputs to zero.
module conv_depth_accum
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned KERNAL_TAPS = TAPS_DEF,
  parameter int unsigned ANCHOR_POS  = 961,
  parameter int unsigned DATA_DEPTH  = 1,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned POS_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [KERNAL_TAPS*DATA_W-1:0] in_window,
  input  logic [KERNAL_TAPS*DATA_W-1:0] in_weight,
  input  logic signed [ACC_W-1:0]       in_bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       out_data,
  output logic [POS_W-1:0]              out_pos,
  output logic                          frame_done
);

  localparam int unsigned SUM_W   = 2 * DATA_W + clog2_min1(KERNAL_TAPS);
  localparam int unsigned DEPTH_W = clog2_min1(DATA_DEPTH);
  localparam int unsigned ADDR_W  = clog2_min1(ANCHOR_POS);
  localparam int unsigned TAG_W   = ACC_W + POS_W + 2;

  logic                    w_stall;
  logic                    w_enable;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;
  logic [POS_W-1:0]        r_pos;
  logic [DEPTH_W-1:0]      r_depth;
  logic [TAG_W-1:0]        w_in_tag;
  logic [TAG_W-1:0]        w_s2_tag;
  logic                    w_s2_valid;
  logic signed [SUM_W-1:0] w_s2_sum;
  logic signed [ACC_W-1:0] w_s2_bias;
  logic [POS_W-1:0]        w_s2_pos;
  logic                    w_s2_first;
  logic                    w_s2_last;
  logic [ADDR_W-1:0]       w_addr;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_result;
  logic signed [ACC_W-1:0] r_psum [ANCHOR_POS];
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic [POS_W-1:0]        r_out_pos;

  assign w_stall  = r_out_valid && !out_ready;
  assign w_enable = !w_stall;
  assign in_ready = w_enable;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_depth == '0);
  assign w_last   = (r_depth == DEPTH_W'(DATA_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_depth <= '0;
    end else if (clear) begin
      r_pos   <= '0;
      r_depth <= '0;
    end else if (w_accept) begin
      if (r_pos == POS_W'(ANCHOR_POS - 1)) begin
        r_pos   <= '0;
        r_depth <= w_last ? '0 : r_depth + DEPTH_W'(1);
      end else begin
        r_pos <= r_pos + POS_W'(1);
      end
    end
  end

  assign w_in_tag = {in_bias, r_pos, w_first, w_last};

  conv_mac_tree25 #(
    .DATA_W (DATA_W),
    .TAPS   (KERNAL_TAPS),
    .SUM_W  (SUM_W),
    .TAG_W  (TAG_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (clear),
    .i_enable (w_enable),
    .i_valid  (w_accept),
    .i_window (in_window),
    .i_weight (in_weight),
    .i_tag    (w_in_tag),
    .o_valid  (w_s2_valid),
    .o_sum    (w_s2_sum),
    .o_tag    (w_s2_tag)
  );

  assign {w_s2_bias, w_s2_pos, w_s2_first, w_s2_last} = w_s2_tag;
  assign w_addr    = w_s2_pos[ADDR_W-1:0];
  assign w_sum_ext = ACC_W'(w_s2_sum);
  assign w_acc     = w_s2_first ? (w_sum_ext + w_s2_bias) : (r_psum[w_addr] + w_sum_ext);

`ifdef CONV_ACCUM_RELU_EN
  assign w_result = w_acc[ACC_W-1] ? '0 : w_acc;
`else
  assign w_result = w_acc;
`endif

  // Same anchor recurs ANCHOR_POS beats later, so a plain async-read array has no hazard.
  always_ff @(posedge clk) begin
    if (w_enable && !clear && w_s2_valid && !w_s2_last) begin
      r_psum[w_addr] <= w_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_pos   <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_enable) begin
      r_out_valid <= w_s2_valid && w_s2_last;
      if (w_s2_valid && w_s2_last) begin
        r_out_data <= w_result;
        r_out_pos  <= w_s2_pos;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_pos    = r_out_pos;
  assign frame_done = r_out_valid && out_ready && (r_out_pos == POS_W'(ANCHOR_POS - 1));

endmodule
